vital_energy_accumulator: RTL and testbench

VITAL_ENERGY_ACCUMULATOR -- requirements
Module: vital_energy_accumulator

---
 rtl/vital_energy_accumulator_pkg.sv | 20 ++
 rtl/vital_energy_accumulator_prescaler.sv | 46 ++++
 rtl/vital_energy_accumulator.sv | 126 ++++++++++++
 tb/tb_vital_energy_accumulator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vital_energy_accumulator_pkg.sv
// vital_energy_accumulator_pkg
// Shared constants for the energy accumulator slice. It holds the 2-bit
// quantized level encoding, which matches the neurotransmitter fields, and
// the default step dividers.
// Ports: none (package).
package vital_energy_accumulator_pkg;

    localparam logic [1:0] LVL_LOW      = 2'b00;
    localparam logic [1:0] LVL_MID_LOW  = 2'b01;
    localparam logic [1:0] LVL_MID_HIGH = 2'b10;
    localparam logic [1:0] LVL_HIGH     = 2'b11;

    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_SLOW_DIV = 16;
    localparam int unsigned DEF_FAST_DIV = 4;

    // Wide enough for the largest legal SLOW_DIV (255).
    localparam int unsigned PRESCALE_W = 8;

endpackage

// File: rtl/vital_energy_accumulator_prescaler.sv
// energy_prescaler
// Counts clock cycles while the accumulator is active. It raises tick in
// the cycle where the count has reached div-1. The divider is re-selected
// every cycle, so a fast/slow change keeps the count already reached.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   active     : a single direction is requested; when low the count clears
//   fast       : selects FAST_DIV instead of SLOW_DIV
//   clear      : synchronous clear (setval load or saturation)
//   tick       : combinational, high when a step is due at the next edge
module energy_prescaler
    import vital_energy_accumulator_pkg::*;
#(
    parameter int unsigned SLOW_DIV = DEF_SLOW_DIV,
    parameter int unsigned FAST_DIV = DEF_FAST_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic fast,
    input  logic clear,
    output logic tick
);

    logic [PRESCALE_W-1:0] count;
    logic [PRESCALE_W-1:0] div_m1;

    always_comb begin
        div_m1 = fast ? PRESCALE_W'(FAST_DIV - 1) : PRESCALE_W'(SLOW_DIV - 1);
    end

    // ">=" rather than "==": after a switch to fast the count may already
    // be past the new terminal value, and the step must then occur at once.
    assign tick = active && (count >= div_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || !active || tick) begin
            count <= '0;
        end else begin
            count <= count + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/vital_energy_accumulator.sv
// vital_energy_accumulator
// Saturating energy level that is raised or lowered by one step every
// SLOW_DIV or FAST_DIV clock cycles while exactly one of inc/dec is held.
// A setval load has priority over stepping. level_q is the 2-bit quantized
// level. With the VITAL_ENERGY_HYST_EN macro defined, level_q is given a
// falling hysteresis of HYST LSBs.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   inc, dec    : raise / lower requests (both or neither = idle)
//   fast        : use FAST_DIV as the step period
//   setval      : synchronous load of setval_data
//   setval_data : value to load
//   level       : registered energy level
//   level_q     : registered quantized level (LVL_LOW .. LVL_HIGH)
//   at_min      : level == 0 (combinational)
//   at_max      : level == all-ones (combinational)
//   step        : one-cycle pulse in the cycle after a step changed level
module vital_energy_accumulator
    import vital_energy_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned SLOW_DIV    = DEF_SLOW_DIV,
    parameter int unsigned FAST_DIV    = DEF_FAST_DIV,
    parameter int unsigned RESET_VALUE = 128,
    parameter int unsigned HYST        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             fast,
    input  logic             setval,
    input  logic [WIDTH-1:0] setval_data,
    output logic [WIDTH-1:0] level,
    output logic [1:0]       level_q,
    output logic             at_min,
    output logic             at_max,
    output logic             step
);

    localparam logic [WIDTH-1:0] RST_LEVEL = WIDTH'(RESET_VALUE);

    if (SLOW_DIV < 2 || SLOW_DIV > 255 || FAST_DIV < 1 || FAST_DIV > SLOW_DIV ||
        HYST >= (1 << WIDTH)) begin : g_bad_params
        $error("vital_energy_accumulator: illegal parameter combination");
    end

    logic             active;
    logic             sat;
    logic             tick;
    logic             move;
    logic [WIDTH-1:0] level_next;

    assign active = inc ^ dec;
    // Pushing against a rail holds the level and keeps the prescaler empty.
    assign sat    = active && (inc ? (level == '1) : (level == '0));
    assign move   = tick && !sat && !setval;

    energy_prescaler #(
        .SLOW_DIV (SLOW_DIV),
        .FAST_DIV (FAST_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (active),
        .fast   (fast),
        .clear  (setval || sat),
        .tick   (tick)
    );

    always_comb begin
        level_next = level;
        if (setval) begin
            level_next = setval_data;
        end else if (move) begin
            level_next = inc ? level + WIDTH'(1) : level - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= RST_LEVEL;
            step  <= 1'b0;
        end else begin
            level <= level_next;
            step  <= move;
        end
    end

    assign at_min = (level == '0);
    assign at_max = (level == '1);

`ifdef VITAL_ENERGY_HYST_EN
    logic [1:0] q_reg;
    logic [1:0] band_next;
    int         fall_floor;
    logic       below_floor;

    assign band_next = level_next[WIDTH-1 -: 2];

    // Falling edge of the current band, lowered by HYST; may go negative,
    // in which case the band can never be left downwards.
    always_comb begin
        fall_floor  = (int'(q_reg) << (WIDTH - 2)) - int'(HYST);
        below_floor = (int'(level_next) < fall_floor);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= RST_LEVEL[WIDTH-1 -: 2];
        end else if (setval) begin
            q_reg <= setval_data[WIDTH-1 -: 2];
        end else if (band_next > q_reg) begin
            q_reg <= band_next;
        end else if (band_next < q_reg && below_floor && q_reg != LVL_LOW) begin
            q_reg <= q_reg - 2'd1;
        end
    end

    assign level_q = q_reg;
`else
    // The top bits of the registered level are already a registered quantity.
    assign level_q = level[WIDTH-1 -: 2];
`endif

endmodule

// File: tb/tb_vital_energy_accumulator.sv
module tb_vital_energy_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inc, dec, fast, setval;
    logic [7:0] setval_data;
    logic [7:0] level;
    logic [1:0] level_q;
    logic       at_min, at_max, step;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    int         exp_cyc[$];
    logic [7:0] exp_lvl[$];

    vital_energy_accumulator #(
        .WIDTH       (8),
        .SLOW_DIV    (16),
        .FAST_DIV    (4),
        .RESET_VALUE (128),
        .HYST        (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc         (inc),
        .dec         (dec),
        .fast        (fast),
        .setval      (setval),
        .setval_data (setval_data),
        .level       (level),
        .level_q     (level_q),
        .at_min      (at_min),
        .at_max      (at_max),
        .step        (step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every step pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && step === 1'b1) begin
            if (exp_cyc.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_step: got step at cycle %0d level %0d, expected none",
                         cyc, level);
            end else begin
                chk("step_cycle", cyc, exp_cyc.pop_front());
                chk("step_level", int'(level), int'(exp_lvl.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, expected $finish");
        $fatal(1);
    end

    // Hold one direction for n steps from a cleared prescaler, queueing one
    // expected step per period; start/final are hand-computed by the caller.
    task automatic run_steps(input logic up, input logic f, input int n,
                             input int start, input int final_lvl);
        int   c0;
        int   div;
        int   lv;
        c0  = cyc;
        div = f ? 4 : 16;
        lv  = start;
        for (int k = 1; k <= n; k++) begin
            lv = up ? lv + 1 : lv - 1;
            exp_cyc.push_back(c0 + k * div);
            exp_lvl.push_back(8'(lv));
        end
        inc  = up;
        dec  = !up;
        fast = f;
        repeat (n * div) @(negedge clk);
        inc = 1'b0;
        dec = 1'b0;
        chk("run_level", int'(level), final_lvl);
    endtask

    task automatic load(input logic [7:0] v);
        setval      = 1'b1;
        setval_data = v;
        @(negedge clk);
        setval = 1'b0;
        chk("load_level", int'(level), int'(v));
        chk("load_step", int'(step), 0);
    endtask

    initial begin
        int c0;
        rst_n = 1'b0; inc = 1'b0; dec = 1'b0; fast = 1'b0;
        setval = 1'b0; setval_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_level", int'(level), 128);
        chk("rst_level_q", int'(level_q), 2);
        chk("rst_step", int'(step), 0);
        chk("rst_at_min", int'(at_min), 0);
        chk("rst_at_max", int'(at_max), 0);
        rst_n = 1'b1;

        // Slow inc, 48 cycles: three steps at 16/32/48.
        run_steps(1'b1, 1'b0, 3, 128, 131);
        chk("q_131", int'(level_q), 2);

        // Saturate at 255 with fast inc: one step, then nothing.
        load(8'd254);
        c0 = cyc;
        exp_cyc.push_back(c0 + 4);
        exp_lvl.push_back(8'd255);
        inc = 1'b1; fast = 1'b1;
        repeat (12) @(negedge clk);
        inc = 1'b0;
        chk("sat_level", int'(level), 255);
        chk("sat_at_max", int'(at_max), 1);
        chk("sat_q", int'(level_q), 3);

        // Slow dec for 10 cycles, then fast: step on the very next edge.
        c0 = cyc;
        exp_cyc.push_back(c0 + 11);
        exp_lvl.push_back(8'd254);
        dec = 1'b1; fast = 1'b0;
        repeat (10) @(negedge clk);
        fast = 1'b1;
        @(negedge clk);
        dec = 1'b0;
        chk("fast_switch_level", int'(level), 254);

        // Both requests high: idle.
        inc = 1'b1; dec = 1'b1; fast = 1'b0;
        repeat (40) @(negedge clk);
        dec = 1'b0;
        chk("idle_level", int'(level), 254);
        // setval wins over inc.
        setval = 1'b1; setval_data = 8'h05;
        @(negedge clk);
        setval = 1'b0; inc = 1'b0;
        chk("setval_prio_level", int'(level), 5);
        chk("setval_prio_step", int'(step), 0);
        chk("q_5", int'(level_q), 0);

        // Reversal keeps the prescaler: 10 inc cycles + 6 dec cycles = 1 step.
        c0 = cyc;
        exp_cyc.push_back(c0 + 16);
        exp_lvl.push_back(8'd4);
        inc = 1'b1; fast = 1'b0;
        repeat (10) @(negedge clk);
        inc = 1'b0; dec = 1'b1;
        repeat (6) @(negedge clk);
        dec = 1'b0;
        chk("reverse_level", int'(level), 4);

        // Dec at 0 saturates.
        load(8'd0);
        chk("zero_at_min", int'(at_min), 1);
        dec = 1'b1; fast = 1'b1;
        repeat (8) @(negedge clk);
        dec = 1'b0;
        chk("floor_level", int'(level), 0);
        chk("floor_at_min", int'(at_min), 1);

        // Asynchronous reset mid-count at 200.
        load(8'd200);
        chk("q_200", int'(level_q), 3);
        inc = 1'b1; fast = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_level", int'(level), 128);
        chk("async_rst_q", int'(level_q), 2);
        chk("async_rst_step", int'(step), 0);
        repeat (2) @(negedge clk);
        c0 = cyc;
        exp_cyc.push_back(c0 + 16);
        exp_lvl.push_back(8'd129);
        rst_n = 1'b1;
        repeat (16) @(negedge clk);
        inc = 1'b0;
        chk("post_rst_level", int'(level), 129);

`ifdef VITAL_ENERGY_HYST_EN
        load(8'd64);
        chk("hyst_q_64", int'(level_q), 1);
        run_steps(1'b0, 1'b1, 1, 64, 63);
        chk("hyst_q_63", int'(level_q), 1);
        run_steps(1'b0, 1'b1, 7, 63, 56);
        chk("hyst_q_56", int'(level_q), 1);
        run_steps(1'b0, 1'b1, 1, 56, 55);
        chk("hyst_q_55", int'(level_q), 0);
        run_steps(1'b1, 1'b1, 9, 55, 64);
        chk("hyst_q_up64", int'(level_q), 1);
`endif

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", exp_cyc.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
